secure_ctrl: RTL and testbench

SECURE_CTRL -- requirements
Module: secure_ctrl

---
 rtl/secure_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_secure_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_ctrl.sv
// Authenticated command controller: LFSR challenge/response login with lockout,
// RSA-wrapped memory access. Optional wait timeout via SECURE_CTRL_TIMEOUT_EN.
module secure_ctrl #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [15:0] NONCE_SEED     = 16'hACE1,
  parameter int          MAX_FAILS      = 3,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MODULUS        = 3233,
  parameter int          PUB_KEY        = 17,
  parameter int          PRIV_KEY       = 2753
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [2:0]            i_opcode,
  input  logic [DATA_WIDTH-1:0] i_datain,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_cu_ready,
  output logic [DATA_WIDTH-1:0] o_dataout,
  output logic [2:0]            o_status,
  output logic                  o_locked,
  output logic [DATA_WIDTH-1:0] o_rsa_datain,
  output logic [DATA_WIDTH-1:0] o_rsa_modulusin,
  output logic [DATA_WIDTH-1:0] o_rsa_keyin,
  output logic                  o_rsa_en,
  input  logic [DATA_WIDTH-1:0] i_rsa_dataout,
  input  logic                  i_rsa_ready,
  output logic [DATA_WIDTH-1:0] o_mem_datain,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_op,
  output logic                  o_mem_en,
  input  logic [DATA_WIDTH-1:0] i_mem_dataout,
  input  logic                  i_mem_ready
);

  localparam logic [2:0] OP_AUTH_START = 3'd0;
  localparam logic [2:0] OP_AUTH_RESP  = 3'd1;
  localparam logic [2:0] OP_MEM_READ   = 3'd2;
  localparam logic [2:0] OP_MEM_WRITE  = 3'd3;
  localparam logic [2:0] OP_RSA_ENC    = 3'd4;
  localparam logic [2:0] OP_RSA_DEC    = 3'd5;
  localparam logic [2:0] OP_LOGOUT     = 3'd6;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_INVALID   = 3'd1;
  localparam logic [2:0] ST_NOT_AUTH  = 3'd2;
  localparam logic [2:0] ST_AUTH_FAIL = 3'd3;
  localparam logic [2:0] ST_TIMEOUT   = 3'd4;
  localparam logic [2:0] ST_LOCKED    = 3'd5;

  localparam logic [DATA_WIDTH-1:0] PUB_OPERAND  = DATA_WIDTH'(PUB_KEY);
  localparam logic [DATA_WIDTH-1:0] PRIV_OPERAND = DATA_WIDTH'(PRIV_KEY);

  typedef enum logic [2:0] {
    S_IDLE, S_RSA_REQ, S_RSA_WAIT, S_MEM_REQ, S_MEM_WAIT, S_FINISH, S_LOCK
  } state_t;

  state_t                r_state, w_state_next;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_res;
  logic [15:0]           r_lfsr, r_chal;
  logic                  r_chal_valid, r_auth;
  logic [3:0]            r_fails;
  logic [DATA_WIDTH-1:0] r_dataout;
  logic [2:0]            r_status;
  logic                  r_locked;
  logic [DATA_WIDTH-1:0] r_rsa_datain, r_rsa_keyin, r_mem_datain;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_op, r_rsa_en, r_mem_en;

  logic                  w_timeout, w_auth_fail, w_lock;
  logic [3:0]            w_fails_inc;
  logic [15:0]           w_lfsr_step;

  assign w_lfsr_step = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

`ifdef SECURE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (r_state == S_RSA_REQ || r_state == S_MEM_REQ) begin
      r_timer <= '0;
    end else if (r_state == S_RSA_WAIT || r_state == S_MEM_WAIT) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
  // Constant false: waits are unbounded in this build.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fails_inc  = r_fails + 4'd1;
    w_auth_fail  = !r_chal_valid || (r_res != DATA_WIDTH'(r_chal));
    w_lock       = (r_op == OP_AUTH_RESP) && w_auth_fail && (w_fails_inc >= 4'(MAX_FAILS));
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_opcode)
            OP_AUTH_RESP: w_state_next = r_chal_valid ? S_RSA_REQ : S_FINISH;
            OP_MEM_READ:  w_state_next = r_auth ? S_MEM_REQ : S_FINISH;
            OP_MEM_WRITE, OP_RSA_ENC, OP_RSA_DEC:
                          w_state_next = r_auth ? S_RSA_REQ : S_FINISH;
            default:      w_state_next = S_FINISH;
          endcase
        end
      end
      S_RSA_REQ:  w_state_next = S_RSA_WAIT;
      S_RSA_WAIT: begin
        if (i_rsa_ready)    w_state_next = (r_op == OP_MEM_WRITE) ? S_MEM_REQ : S_FINISH;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_MEM_REQ:  w_state_next = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (i_mem_ready)    w_state_next = (r_op == OP_MEM_READ) ? S_RSA_REQ : S_FINISH;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_FINISH:   w_state_next = w_lock ? S_LOCK : S_IDLE;
      S_LOCK:     w_state_next = S_LOCK;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op         <= '0;
      r_addr       <= '0;
      r_res        <= '0;
      r_lfsr       <= NONCE_SEED;
      r_chal       <= '0;
      r_chal_valid <= 1'b0;
      r_auth       <= 1'b0;
      r_fails      <= '0;
      r_dataout    <= '0;
      r_status     <= ST_OK;
      r_locked     <= 1'b0;
      r_rsa_datain <= '0;
      r_rsa_keyin  <= '0;
      r_rsa_en     <= 1'b0;
      r_mem_datain <= '0;
      r_mem_addr   <= '0;
      r_mem_op     <= 1'b0;
      r_mem_en     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_op   <= i_opcode;
            r_addr <= i_addr;
            if (w_state_next == S_RSA_REQ) begin
              r_rsa_datain <= i_datain;
              r_rsa_keyin  <= (i_opcode == OP_AUTH_RESP || i_opcode == OP_RSA_DEC)
                              ? PRIV_OPERAND : PUB_OPERAND;
            end
            if (w_state_next == S_MEM_REQ) begin
              r_mem_addr <= i_addr;
              r_mem_op   <= 1'b0;
            end
          end
        end
        S_RSA_REQ: r_rsa_en <= 1'b1;
        S_RSA_WAIT: begin
          if (i_rsa_ready) begin
            r_rsa_en <= 1'b0;
            r_res    <= i_rsa_dataout;
            if (r_op == OP_MEM_WRITE) begin
              r_mem_datain <= i_rsa_dataout;
              r_mem_addr   <= r_addr;
              r_mem_op     <= 1'b1;
            end
          end else if (w_timeout) begin
            r_rsa_en <= 1'b0;
            r_status <= ST_TIMEOUT;
          end
        end
        S_MEM_REQ: r_mem_en <= 1'b1;
        S_MEM_WAIT: begin
          if (i_mem_ready) begin
            r_mem_en <= 1'b0;
            // Read data goes straight on to decryption.
            if (r_op == OP_MEM_READ) begin
              r_rsa_datain <= i_mem_dataout;
              r_rsa_keyin  <= PRIV_OPERAND;
            end
          end else if (w_timeout) begin
            r_mem_en <= 1'b0;
            r_status <= ST_TIMEOUT;
          end
        end
        S_FINISH: begin
          case (r_op)
            OP_AUTH_START: begin
              r_dataout    <= DATA_WIDTH'(r_lfsr);
              r_chal       <= r_lfsr;
              r_chal_valid <= 1'b1;
              r_lfsr       <= w_lfsr_step;
              r_status     <= ST_OK;
            end
            OP_AUTH_RESP: begin
              r_chal_valid <= 1'b0;
              if (!w_auth_fail) begin
                r_auth    <= 1'b1;
                r_fails   <= '0;
                r_dataout <= '0;
                r_status  <= ST_OK;
              end else begin
                r_fails  <= w_fails_inc;
                r_status <= w_lock ? ST_LOCKED : ST_AUTH_FAIL;
                r_locked <= w_lock;
              end
            end
            OP_MEM_READ, OP_MEM_WRITE, OP_RSA_ENC, OP_RSA_DEC: begin
              if (r_auth) begin
                r_dataout <= r_res;
                r_status  <= ST_OK;
              end else begin
                r_status  <= ST_NOT_AUTH;
              end
            end
            OP_LOGOUT: begin
              r_auth   <= 1'b0;
              r_status <= ST_OK;
            end
            default: begin
              r_auth   <= 1'b0;
              r_status <= ST_INVALID;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_cu_ready      = (r_state == S_IDLE) || (r_state == S_LOCK);
  assign o_dataout       = r_dataout;
  assign o_status        = r_status;
  assign o_locked        = r_locked;
  assign o_rsa_datain    = r_rsa_datain;
  assign o_rsa_modulusin = DATA_WIDTH'(MODULUS);
  assign o_rsa_keyin     = r_rsa_keyin;
  assign o_rsa_en        = r_rsa_en;
  assign o_mem_datain    = r_mem_datain;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_op        = r_mem_op;
  assign o_mem_en        = r_mem_en;

endmodule

// File: tb/tb_secure_ctrl.sv
// Bench for secure_ctrl: identity RSA responder (3-cycle latency), 2-cycle memory,
// and a command-level reference model of the controller rules.
module tb_secure_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MAXF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    opcode = '0;
  logic [DW-1:0] datain = '0;
  logic [AW-1:0] addr = '0;
  logic          cu_ready, locked, rsa_en, mem_en, mem_op;
  logic [DW-1:0] dataout, rsa_datain, rsa_modulusin, rsa_keyin, mem_datain;
  logic [2:0]    status;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rsa_dataout = '0;
  logic          rsa_ready = 1'b0;
  logic [DW-1:0] mem_dataout = '0;
  logic          mem_ready = 1'b0;
  logic          mem_stall = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secure_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_opcode(opcode),
    .i_datain(datain), .i_addr(addr), .o_cu_ready(cu_ready), .o_dataout(dataout),
    .o_status(status), .o_locked(locked), .o_rsa_datain(rsa_datain),
    .o_rsa_modulusin(rsa_modulusin), .o_rsa_keyin(rsa_keyin), .o_rsa_en(rsa_en),
    .i_rsa_dataout(rsa_dataout), .i_rsa_ready(rsa_ready), .o_mem_datain(mem_datain),
    .o_mem_addr(mem_addr), .o_mem_op(mem_op), .o_mem_en(mem_en),
    .i_mem_dataout(mem_dataout), .i_mem_ready(mem_ready)
  );

  // Responders and activity monitor
  int            rsa_cnt = 0, mem_cnt = 0;
  int            rsa_en_cycles = 0, mem_en_cycles = 0, overlap = 0;
  logic [DW-1:0] last_rsa_key = '0, last_mem_din = '0;
  logic [AW-1:0] last_mem_addr = '0;
  logic          last_mem_op = 1'b0;
  logic [DW-1:0] tb_mem [256];

  always @(posedge clk) begin
    if (rsa_en && !rsa_ready) begin
      if (rsa_cnt == 2) begin
        rsa_ready   <= 1'b1;
        rsa_dataout <= rsa_datain;
        rsa_cnt     <= 0;
      end else rsa_cnt <= rsa_cnt + 1;
    end else begin
      rsa_ready <= 1'b0;
      if (!rsa_en) rsa_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (mem_en && !mem_ready && !mem_stall) begin
      if (mem_cnt == 1) begin
        mem_ready <= 1'b1;
        if (mem_op) tb_mem[mem_addr] <= mem_datain;
        else        mem_dataout <= tb_mem[mem_addr];
        mem_cnt <= 0;
      end else mem_cnt <= mem_cnt + 1;
    end else begin
      mem_ready <= 1'b0;
      if (!mem_en) mem_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (rsa_en) begin
      rsa_en_cycles <= rsa_en_cycles + 1;
      last_rsa_key  <= rsa_keyin;
    end
    if (mem_en) begin
      mem_en_cycles <= mem_en_cycles + 1;
      last_mem_op   <= mem_op;
      last_mem_addr <= mem_addr;
      last_mem_din  <= mem_datain;
    end
    if (rsa_en && mem_en) overlap <= overlap + 1;
  end

  // Reference model at command granularity
  logic [15:0]   m_lfsr, m_chal;
  bit            m_chal_valid, m_auth, m_locked;
  int            m_fails;
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] m_dout;
  logic [2:0]    m_status;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] fb;
    fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h0001;
    return (x >> 1) | (fb << 15);
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_chal = '0; m_chal_valid = 0; m_auth = 0;
    m_locked = 0; m_fails = 0; m_dout = '0; m_status = 3'd0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
    if (m_locked) return;
    case (op)
      3'd0: begin
        m_chal = m_lfsr; m_chal_valid = 1; m_dout = DW'(m_lfsr);
        m_lfsr = lfsr_step(m_lfsr); m_status = 3'd0;
      end
      3'd1: begin
        if (m_chal_valid && d == DW'(m_chal)) begin
          m_auth = 1; m_fails = 0; m_status = 3'd0; m_dout = '0;
        end else begin
          m_fails++;
          m_status = 3'd3;
          if (m_fails >= MAXF) begin m_locked = 1; m_status = 3'd5; end
        end
        m_chal_valid = 0;
      end
      3'd2, 3'd3, 3'd4, 3'd5: begin
        if (!m_auth) m_status = 3'd2;
        else begin
          if (op == 3'd2) m_dout = m_mem[a];
          else begin
            if (op == 3'd3) m_mem[a] = d;
            m_dout = d;
          end
          m_status = 3'd0;
        end
      end
      3'd6: begin m_auth = 0; m_status = 3'd0; end
      default: begin m_auth = 0; m_status = 3'd1; end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a,
                        output logic [DW-1:0] dout, output logic [2:0] st, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; opcode = op; datain = d; addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!cu_ready && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (cu_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_done_timeout: cu_ready=%b required 1", cu_ready);
    end
    dout = dataout; st = status;
    $display("cmd op=%0d data=%h addr=%h -> dataout=%h status=%0d lat=%0d", op, d, a, dout, st, lat);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (cu_ready !== 1'b1 || dataout !== '0 || status !== 3'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b dout=%h st=%0d lock=%b required 1/0000/0/0",
               cu_ready, dataout, status, locked);
    end
    checks++;
    if (rsa_en !== 1'b0 || mem_en !== 1'b0 || rsa_modulusin !== DW'(3233) ||
        rsa_keyin !== '0 || rsa_datain !== '0 || mem_addr !== '0 || mem_datain !== '0) begin
      errors++;
      $display("FAIL reset_operands: rsa_en=%b mem_en=%b mod=%0d key=%h required 0/0/3233/0",
               rsa_en, mem_en, rsa_modulusin, rsa_keyin);
    end
  endtask

  task automatic test_unauth();
    logic [DW-1:0] dout; logic [2:0] st; int lat; int r0, m0;
    for (int op = 2; op <= 5; op++) begin
      r0 = rsa_en_cycles; m0 = mem_en_cycles;
      do_cmd(3'(op), DW'($urandom()), 8'h05, dout, st, lat);
      model_cmd(3'(op), '0, 8'h05);
      checks++;
      if (st !== m_status || st !== 3'd2) begin
        errors++;
        $display("FAIL unauth_status op=%0d: got %0d required %0d", op, st, m_status);
      end
      checks++;
      if (rsa_en_cycles != r0 || mem_en_cycles != m0) begin
        errors++;
        $display("FAIL unauth_activity op=%0d: rsa/mem cycles %0d/%0d required 0/0",
                 op, rsa_en_cycles - r0, mem_en_cycles - m0);
      end
    end
  endtask

  task automatic test_auth_mem();
    logic [DW-1:0] dout; logic [2:0] st; int lat;
    // Response with no challenge outstanding
    do_cmd(3'd1, 16'hACE1, '0, dout, st, lat);
    model_cmd(3'd1, 16'hACE1, '0);
    checks++;
    if (st !== 3'd3) begin errors++; $display("FAIL resp_no_chal: status %0d required 3", st); end
    do_cmd(3'd0, '0, '0, dout, st, lat);
    model_cmd(3'd0, '0, '0);
    checks++;
    if (dout !== 16'hACE1 || st !== 3'd0) begin
      errors++; $display("FAIL auth_start: dout=%h st=%0d required ace1/0", dout, st);
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL auth_start_latency: %0d required 1", lat); end
    do_cmd(3'd1, 16'hACE1, '0, dout, st, lat);
    model_cmd(3'd1, 16'hACE1, '0);
    checks++;
    if (st !== 3'd0 || dout !== '0) begin
      errors++; $display("FAIL auth_resp: dout=%h st=%0d required 0000/0", dout, st);
    end
    do_cmd(3'd3, 16'h1234, 8'h05, dout, st, lat);
    model_cmd(3'd3, 16'h1234, 8'h05);
    checks++;
    if (last_mem_op !== 1'b1 || last_mem_addr !== 8'h05 || last_mem_din !== 16'h1234 ||
        dout !== m_dout || st !== 3'd0) begin
      errors++;
      $display("FAIL mem_write: op=%b addr=%h din=%h dout=%h st=%0d required 1/05/1234/%h/0",
               last_mem_op, last_mem_addr, last_mem_din, dout, st, m_dout);
    end
    checks++;
    if (last_rsa_key !== DW'(17)) begin
      errors++; $display("FAIL write_key: %0d required 17", last_rsa_key);
    end
    do_cmd(3'd2, '0, 8'h05, dout, st, lat);
    model_cmd(3'd2, '0, 8'h05);
    checks++;
    if (dout !== 16'h1234 || st !== 3'd0) begin
      errors++; $display("FAIL mem_read: dout=%h st=%0d required 1234/0", dout, st);
    end
    checks++;
    if (last_rsa_key !== DW'(2753) || last_mem_op !== 1'b0) begin
      errors++; $display("FAIL read_key: key=%0d op=%b required 2753/0", last_rsa_key, last_mem_op);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dout, d; logic [2:0] st, op; logic [AW-1:0] a; int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = DW'($urandom());
      a  = AW'($urandom_range(0, 7));
      if (!m_auth && $urandom_range(0, 1) == 1) op = m_chal_valid ? 3'd1 : 3'd0;
      if (op == 3'd1 && m_chal_valid && $urandom_range(0, 1) == 1) d = DW'(m_chal);
      if (op == 3'd1 && m_fails >= MAXF - 1) begin
        if (m_chal_valid) d = DW'(m_chal);
        else op = 3'd0;
      end
      do_cmd(op, d, a, dout, st, lat);
      model_cmd(op, d, a);
      checks++;
      if (dout !== m_dout || st !== m_status) begin
        errors++;
        $display("FAIL random[%0d] op=%0d: dout=%h st=%0d required %h/%0d",
                 i, op, dout, st, m_dout, m_status);
      end
    end
  endtask

  task automatic login();
    logic [DW-1:0] dout; logic [2:0] st; int lat;
    do_cmd(3'd0, '0, '0, dout, st, lat);
    model_cmd(3'd0, '0, '0);
    do_cmd(3'd1, DW'(m_chal), '0, dout, st, lat);
    model_cmd(3'd1, DW'(m_chal), '0);
    checks++;
    if (st !== 3'd0 || dout !== m_dout) begin
      errors++; $display("FAIL login: dout=%h st=%0d required %h/0", dout, st, m_dout);
    end
  endtask

`ifdef SECURE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] dout; logic [2:0] st; int lat; int m0;
    login();
    mem_stall = 1'b1;
    m0 = mem_en_cycles;
    do_cmd(3'd2, '0, 8'h03, dout, st, lat);
    checks++;
    if (st !== 3'd4 || dout !== m_dout || mem_en !== 1'b0) begin
      errors++; $display("FAIL timeout_status: st=%0d dout=%h mem_en=%b required 4/%h/0",
                         st, dout, mem_en, m_dout);
    end
    checks++;
    if (mem_en_cycles - m0 != 16) begin
      errors++; $display("FAIL timeout_cycles: %0d required 16", mem_en_cycles - m0);
    end
    mem_stall = 1'b0;
    do_cmd(3'd4, 16'h0042, '0, dout, st, lat);
    model_cmd(3'd4, 16'h0042, '0);
    checks++;
    if (dout !== 16'h0042 || st !== 3'd0) begin
      errors++; $display("FAIL after_timeout_enc: dout=%h st=%0d required 0042/0", dout, st);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [DW-1:0] dout; logic [2:0] st; int lat, n;
    login();
    @(negedge clk);
    cmd_valid = 1'b1; opcode = 3'd4; datain = 16'h5555;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsa_en && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsa_en !== 1'b1) begin errors++; $display("FAIL midreset_wait: rsa_en=%b required 1", rsa_en); end
    rst = 1'b1; cmd_valid = 1'b1; opcode = 3'd0;
    @(negedge clk);
    checks++;
    if (rsa_en !== 1'b0 || cu_ready !== 1'b1 || status !== 3'd0 || dataout !== '0) begin
      errors++; $display("FAIL midreset_state: rsa_en=%b ready=%b st=%0d dout=%h required 0/1/0/0000",
                         rsa_en, cu_ready, status, dataout);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    model_reset();
    do_cmd(3'd2, '0, 8'h05, dout, st, lat);
    model_cmd(3'd2, '0, 8'h05);
    checks++;
    if (st !== 3'd2) begin errors++; $display("FAIL midreset_unauth: st=%0d required 2", st); end
  endtask

  task automatic test_lockout();
    logic [DW-1:0] dout, dhold; logic [2:0] st; int lat; int m0;
    logic [2:0] want [3];
    want[0] = 3'd3; want[1] = 3'd3; want[2] = 3'd5;
    for (int k = 0; k < 3; k++) begin
      do_cmd(3'd0, '0, '0, dout, st, lat);
      model_cmd(3'd0, '0, '0);
      checks++;
      if (dout !== m_dout) begin
        errors++; $display("FAIL lock_chal[%0d]: dout=%h required %h", k, dout, m_dout);
      end
      do_cmd(3'd1, 16'h0000, '0, dout, st, lat);
      model_cmd(3'd1, 16'h0000, '0);
      checks++;
      if (st !== want[k] || st !== m_status) begin
        errors++; $display("FAIL lock_resp[%0d]: st=%0d required %0d", k, st, want[k]);
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL locked_flag: %b required 1", locked); end
    dhold = dataout; m0 = mem_en_cycles;
    do_cmd(3'd2, '0, 8'h05, dout, st, lat);
    checks++;
    if (st !== 3'd5 || dout !== dhold || locked !== 1'b1 || cu_ready !== 1'b1 ||
        mem_en_cycles != m0) begin
      errors++; $display("FAIL lock_ignore: st=%0d dout=%h lock=%b required 5/%h/1", st, dout, locked, dhold);
    end
    apply_reset();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL unlock_reset: %b required 0", locked); end
    do_cmd(3'd0, '0, '0, dout, st, lat);
    model_cmd(3'd0, '0, '0);
    checks++;
    if (dout !== 16'hACE1) begin errors++; $display("FAIL reseed: dout=%h required ace1", dout); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; m_mem[i] = '0; end
    model_reset();
    test_reset();
    test_unauth();
    test_auth_mem();
    test_random();
`ifdef SECURE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_lockout();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL en_overlap: %0d cycles required 0", overlap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
